// File: rtl/seg7_pkg.sv
// Shared types and active-low segment patterns for the seven-segment display path.
package seg7_pkg;

  // Four BCD digits; index 0 is the least significant digit.
  typedef logic [0:3][0:3] bcd4_t;

  // Segment bit order is {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_D0 = 7'h40;
  localparam logic [6:0] SEG_D1 = 7'h79;
  localparam logic [6:0] SEG_D2 = 7'h24;
  localparam logic [6:0] SEG_D3 = 7'h30;
  localparam logic [6:0] SEG_D4 = 7'h19;
  localparam logic [6:0] SEG_D5 = 7'h12;
  localparam logic [6:0] SEG_D6 = 7'h02;
  localparam logic [6:0] SEG_D7 = 7'h78;
  localparam logic [6:0] SEG_D8 = 7'h00;
  localparam logic [6:0] SEG_D9 = 7'h10;

endpackage

// File: rtl/seg7_encode.sv
// Combinational 4-bit value to active-low seven-segment pattern.
// Non-BCD values (10..15) render as a dash so bad data is visible on the board.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  // Pattern lookup; anything outside 0..9 falls through to the dash.
  always_comb begin
    o_seg = SEG_DASH;
    case (i_val)
      4'd0: o_seg = SEG_D0;
      4'd1: o_seg = SEG_D1;
      4'd2: o_seg = SEG_D2;
      4'd3: o_seg = SEG_D3;
      4'd4: o_seg = SEG_D4;
      4'd5: o_seg = SEG_D5;
      4'd6: o_seg = SEG_D6;
      4'd7: o_seg = SEG_D7;
      4'd8: o_seg = SEG_D8;
      4'd9: o_seg = SEG_D9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_digit_scanner.sv
// Four-digit multiplexed seven-segment driver fed from the frame counter's BCD bus.
// Digits are captured into a snapshot on startOfFrame so a slot never shows a torn
// frame; each slot begins with GUARD dark cycles to avoid ghosting between anodes.
module bcd_digit_scanner
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV      = 50000,
  parameter int GUARD         = 16,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  bcd4_t       num,
  input  logic        enable,
  output logic [3:0]  an,
  output logic [6:0]  segN,
  output logic        errFlag
);

  localparam int             CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);

  bcd4_t         r_snap;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_slot;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_err;

  logic          w_in_guard;
  logic [3:0]    w_zero_from;
  logic          w_slot_blanked;
  logic          w_off;
  logic          w_num_bad;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_digit;

  // A zero-length guard must never compare against zero on an unsigned counter.
  generate
    if (GUARD > 0) begin : g_guard
      assign w_in_guard = (r_cnt < CW'(GUARD));
    end else begin : g_no_guard
      assign w_in_guard = 1'b0;
    end
  endgenerate

  // Leading-zero detection: w_zero_from[i] is set when digits i..3 are all zero.
  always_comb begin
    w_zero_from[3] = (r_snap[3] == 4'd0);
    w_zero_from[2] = w_zero_from[3] && (r_snap[2] == 4'd0);
    w_zero_from[1] = w_zero_from[2] && (r_snap[1] == 4'd0);
    w_zero_from[0] = w_zero_from[1] && (r_snap[0] == 4'd0);
    w_slot_blanked = (BLANK_LEADING != 0) && (r_slot != 2'd0) && w_zero_from[r_slot];
    w_off          = !enable || w_in_guard || w_slot_blanked;
  end

  // Any non-BCD digit on the live bus at capture time trips the sticky flag.
  always_comb begin
    w_num_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (num[i] > 4'd9) w_num_bad = 1'b1;
    end
  end

  assign w_digit = r_snap[r_slot];

  seg7_encode u_encode (
    .i_val (w_digit),
    .o_seg (w_seg_digit)
  );

  // Snapshot capture and sticky error flag; capture ignores enable.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_snap <= '0;
      r_err  <= 1'b0;
    end else if (startOfFrame) begin
      r_snap <= num;
      if (w_num_bad) r_err <= 1'b1;
    end
  end

  // Prescaler and slot counter; both freeze while the scan is disabled.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt  <= '0;
      r_slot <= 2'd0;
    end else if (enable) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt  <= '0;
        r_slot <= r_slot + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Registered pin drivers, selected from the current scan state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else if (w_off) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(4'b0001 << r_slot);
      r_seg <= w_seg_digit;
    end
  end

  assign an      = r_an;
  assign segN    = r_seg;
  assign errFlag = r_err;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Bench for bcd_digit_scanner: one leading-zero-blanking instance and one showing all digits.
module tb_bcd_digit_scanner;
  import seg7_pkg::*;

  localparam int SD = 8;
  localparam int G  = 2;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        sof = 1'b0;
  logic        enable = 1'b1;
  bcd4_t       num = '0;
  logic [3:0]  an_b, an_n;
  logic [6:0]  seg_b, seg_n;
  logic        err_b, err_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (plain integers)
  int          m_cnt, m_slot;
  int          m_snap [4];
  bit          m_err;
  logic [3:0]  e_an_b, e_an_n;
  logic [6:0]  e_seg_b, e_seg_n;
  int          shown_slot, shown_cnt;

  typedef struct {
    logic [3:0][3:0] dig;
    logic [3:0][3:0] an_b;
    logic [3:0][6:0] seg_b;
    logic [3:0][3:0] an_n;
    logic [3:0][6:0] seg_n;
    logic            err;
  } vec_t;

  vec_t tbl [6];

  bcd_digit_scanner #(.SCAN_DIV(SD), .GUARD(G), .BLANK_LEADING(1)) u_dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .num(num), .enable(enable),
    .an(an_b), .segN(seg_b), .errFlag(err_b)
  );

  bcd_digit_scanner #(.SCAN_DIV(SD), .GUARD(G), .BLANK_LEADING(0)) u_dut_n (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .num(num), .enable(enable),
    .an(an_n), .segN(seg_n), .errFlag(err_n)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] code(int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_slot = 0; m_err = 0;
    for (int k = 0; k < 4; k++) m_snap[k] = 0;
    e_an_b = 4'hF; e_an_n = 4'hF; e_seg_b = 7'h7F; e_seg_n = 7'h7F;
    shown_slot = 0; shown_cnt = 0;
  endtask

  // One clock edge of the behavioural display: outputs reflect the pre-edge state.
  task automatic model_edge();
    bit off_c, blk;
    off_c = !enable || (m_cnt < G);
    blk = 0;
    if (m_slot > 0) begin
      blk = 1;
      for (int j = m_slot; j < 4; j++) if (m_snap[j] != 0) blk = 0;
    end
    e_an_n  = off_c ? 4'hF : ~(4'b0001 << m_slot);
    e_seg_n = off_c ? 7'h7F : code(m_snap[m_slot]);
    e_an_b  = (off_c || blk) ? 4'hF : ~(4'b0001 << m_slot);
    e_seg_b = (off_c || blk) ? 7'h7F : code(m_snap[m_slot]);
    shown_slot = m_slot;
    shown_cnt  = m_cnt;
    if (sof) begin
      for (int k = 0; k < 4; k++) begin
        if (int'(num[k]) > 9) m_err = 1;
        m_snap[k] = int'(num[k]);
      end
    end
    if (enable) begin
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        m_slot = (m_slot + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic tick();
    if (resetN) model_edge();
    @(posedge clk);
    #1;
    check("model_blank", 32'({an_b, seg_b, err_b}), 32'({e_an_b, e_seg_b, m_err}));
    check("model_noblank", 32'({an_n, seg_n, err_n}), 32'({e_an_n, e_seg_n, m_err}));
  endtask

  task automatic capture(logic [3:0][3:0] d);
    for (int k = 0; k < 4; k++) num[k] = d[k];
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  // One full scan, comparing mid-slot outputs against hand-written table values.
  task automatic scan_vs_table(int i);
    for (int c = 0; c < 4 * SD; c++) begin
      tick();
      if (shown_cnt == 5) begin
        check("tbl_an_b",  32'(an_b),  32'(tbl[i].an_b[shown_slot]));
        check("tbl_seg_b", 32'(seg_b), 32'(tbl[i].seg_b[shown_slot]));
        check("tbl_an_n",  32'(an_n),  32'(tbl[i].an_n[shown_slot]));
        check("tbl_seg_n", 32'(seg_n), 32'(tbl[i].seg_n[shown_slot]));
        check("tbl_err",   32'(err_b), 32'(tbl[i].err));
      end
    end
  endtask

  task automatic run_until(int slot, int cnt, string nm);
    int guard_ticks = 0;
    while (!(m_slot == slot && m_cnt == cnt) && guard_ticks < 8 * SD) begin
      tick();
      guard_ticks++;
    end
    if (guard_ticks >= 8 * SD) check({nm, "_timeout"}, 32'(guard_ticks), 32'(0));
  endtask

  initial begin
    tbl[0] = '{16'h0042, 16'hFFDE, {7'h7F, 7'h7F, 7'h19, 7'h24},
               16'h7BDE, {7'h40, 7'h40, 7'h19, 7'h24}, 1'b0};
    tbl[1] = '{16'h7777, 16'h7BDE, {7'h78, 7'h78, 7'h78, 7'h78},
               16'h7BDE, {7'h78, 7'h78, 7'h78, 7'h78}, 1'b0};
    tbl[2] = '{16'h0000, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40},
               16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
    tbl[3] = '{16'h0500, 16'hFBDE, {7'h7F, 7'h12, 7'h40, 7'h40},
               16'h7BDE, {7'h40, 7'h12, 7'h40, 7'h40}, 1'b0};
    tbl[4] = '{16'h001B, 16'hFFDE, {7'h7F, 7'h7F, 7'h79, 7'h3F},
               16'h7BDE, {7'h40, 7'h40, 7'h79, 7'h3F}, 1'b1};
    tbl[5] = '{16'h3689, 16'h7BDE, {7'h30, 7'h02, 7'h00, 7'h10},
               16'h7BDE, {7'h30, 7'h02, 7'h00, 7'h10}, 1'b1};

    model_reset();
    #12;
    check("reset_hold_b", 32'({an_b, seg_b, err_b}), 32'({4'hF, 7'h7F, 1'b0}));
    check("reset_hold_n", 32'({an_n, seg_n, err_n}), 32'({4'hF, 7'h7F, 1'b0}));
    @(posedge clk);
    #1;
    resetN = 1'b1;
    tick(); check("release_c1_an", 32'(an_b), 32'(4'hF));
    tick(); check("release_c2_an", 32'(an_b), 32'(4'hF));
    tick(); check("release_c3_lit", 32'({an_b, seg_b}), 32'({4'hE, 7'h40}));

    // Table vectors, each viewed one full scan after its capture
    for (int i = 0; i < 6; i++) begin
      capture(tbl[i].dig);
      repeat (4 * SD) tick();
      scan_vs_table(i);
      if (i == 0) begin
        // Live bus changes without a strobe must not reach the display
        for (int k = 0; k < 4; k++) num[k] = 4'd7;
        scan_vs_table(0);
        scan_vs_table(0);
      end
    end

    // Enable gating: freeze mid-slot 1, then resume in slot 1
    begin
      int offc = 0;
      logic [3:0] first_an = 4'hF;
      int waited = 0;
      run_until(1, 5, "gate_seek");
      enable = 1'b0;
      tick();
      check("gate_off_next", 32'({an_b, seg_b}), 32'({4'hF, 7'h7F}));
      repeat (20) begin
        tick();
        if (an_b == 4'hF && seg_b == 7'h7F) offc++;
      end
      check("gate_frozen_off", 32'(offc), 32'(20));
      enable = 1'b1;
      while (first_an == 4'hF && waited < 2 * SD) begin
        tick();
        first_an = an_b;
        waited++;
      end
      check("gate_resume_slot", 32'(first_an), 32'(4'hD));
    end

    // Asynchronous reset during slot 2
    run_until(2, 4, "rst_seek");
    #2;
    resetN = 1'b0;
    #1;
    check("async_rst_b", 32'({an_b, seg_b, err_b}), 32'({4'hF, 7'h7F, 1'b0}));
    check("async_rst_n", 32'({an_n, seg_n, err_n}), 32'({4'hF, 7'h7F, 1'b0}));
    model_reset();
    tick();
    tick();
    resetN = 1'b1;
    tick(); tick();
    tick(); check("rst_restart_slot0", 32'({an_b, seg_b}), 32'({4'hE, 7'h40}));

    // Randomised traffic against the model
    for (int r = 0; r < 900; r++) begin
      sof = ($urandom_range(0, 11) == 0);
      if (sof) begin
        int top;
        top = $urandom_range(0, 4);
        for (int k = 0; k < 4; k++) begin
          if (k >= top) num[k] = 4'd0;
          else if ($urandom_range(0, 29) == 0) num[k] = 4'($urandom_range(10, 15));
          else num[k] = 4'($urandom_range(0, 9));
        end
      end
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      tick();
    end
    sof = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
